// File: rtl/fda_pkt_pkg.sv
// Shared definitions for the accumulator frame packetizers.
// PKT_CHECKSUM_EN adds the trailing checksum byte to every frame.
package fda_pkt_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [6:0] {
        ST_IDLE = 7'b000_0001,
        ST_SYNC = 7'b000_0010,
        ST_SEQ  = 7'b000_0100,
        ST_LOAD = 7'b000_1000,
        ST_HI   = 7'b001_0000,
        ST_LO   = 7'b010_0000,
        ST_CHK  = 7'b100_0000
    } pktState_e;

    // Total bytes on the wire for one frame of the given word count.
    function automatic int frame_bytes(input int words);
`ifdef PKT_CHECKSUM_EN
        return 3 + 2 * words;
`else
        return 2 + 2 * words;
`endif
    endfunction

endpackage

// File: rtl/pkt_tx_hold.sv
// Byte holding register in front of a valid/ready sink: once valid is raised, the byte
// stays put until the sink accepts it.
module pkt_tx_hold (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] loadData,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       accept
);

    assign accept = tx_valid & tx_ready;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (load && (!tx_valid || accept)) begin
            tx_data  <= loadData;
            tx_valid <= 1'b1;
        end else if (accept) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/accum_frame_packetizer.sv
// Drains 16-bit sums from a FWFT FIFO and sends them as SYNC/SEQ/data frames to a UART.
// Define PKT_CHECKSUM_EN to append an 8-bit checksum of SEQ and data bytes.
module accum_frame_packetizer
    import fda_pkt_pkg::*;
#(
    parameter int         WORDS_PER_FRAME = 128,
    parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE,
    parameter int         STALL_LIMIT     = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        underrun,
    output logic [7:0]  frame_seq
);

    localparam int WCNT_W  = $clog2(WORDS_PER_FRAME + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [WCNT_W-1:0]  WORDS_MAX = WCNT_W'(WORDS_PER_FRAME);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    pktState_e          state;
    logic [15:0]        wordReg;
    logic [WCNT_W-1:0]  wordCnt;
    logic [WCNT_W-1:0]  nextCnt;
    logic [STALL_W-1:0] stallCnt;
    logic [7:0]         seqCnt;
    logic               load;
    logic [7:0]         loadData;
    logic               accept;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]         chkSum;
`endif

    assign nextCnt    = wordCnt + 1'b1;
    assign fifo_rd_en = (state == ST_LOAD) && !fifo_empty;

    pkt_tx_hold u_txHold (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .loadData (loadData),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .accept   (accept)
    );

    // Next byte to present; loads only happen when the holder is empty or draining this cycle.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        load     = 1'b0;
        loadData = 8'h00;
        unique case (state)
            ST_IDLE: if (!fifo_empty) begin load = 1'b1; loadData = SYNC_BYTE;         end
            ST_SYNC: if (accept)      begin load = 1'b1; loadData = seqCnt;            end
            ST_LOAD: if (!fifo_empty) begin load = 1'b1; loadData = fifo_dout[15:8];   end
            ST_HI:   if (accept)      begin load = 1'b1; loadData = wordReg[7:0];      end
`ifdef PKT_CHECKSUM_EN
            ST_LO:   if (accept && !(nextCnt < WORDS_MAX)) begin
                load     = 1'b1;
                loadData = chkSum + tx_data;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            frame_seq <= 8'h00;
            seqCnt    <= 8'h00;
            wordReg   <= 16'h0000;
            wordCnt   <= '0;
            stallCnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (!fifo_empty) begin
                    state <= ST_SYNC;
                    busy  <= 1'b1;
                end
                ST_SYNC: begin
                    wordCnt <= '0;
                    if (accept) state <= ST_SEQ;
                end
                ST_SEQ: if (accept) state <= ST_LOAD;
                ST_LOAD: begin
                    if (!fifo_empty) begin
                        wordReg  <= fifo_dout;
                        stallCnt <= '0;
                        state    <= ST_HI;
                    end else if (stallCnt == STALL_MAX) begin
                        underrun <= 1'b1;
                    end else begin
                        stallCnt <= stallCnt + 1'b1;
                    end
                end
                ST_HI: if (accept) state <= ST_LO;
                ST_LO: if (accept) begin
                    wordCnt <= nextCnt;
                    if (nextCnt < WORDS_MAX) begin
                        state <= ST_LOAD;
`ifdef PKT_CHECKSUM_EN
                    end else begin
                        state <= ST_CHK;
                    end
                end
                ST_CHK: if (accept) begin
`else
                    end else begin
`endif
                        frame_seq <= seqCnt;
                        seqCnt    <= seqCnt + 8'd1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PKT_CHECKSUM_EN
    // Running sum of SEQ and data bytes as they are accepted.
    always_ff @(posedge clk) begin
        if (rst || state == ST_SYNC) begin
            chkSum <= 8'h00;
        end else if (accept && (state == ST_SEQ || state == ST_HI || state == ST_LO)) begin
            chkSum <= chkSum + tx_data;
        end
    end
`endif

endmodule
